// File: rtl/jesd_rx_lane_deskew_if.sv
// jesd_rx_lane_deskew_if: lane data in, deskewed data and link status out
interface jesd_rx_lane_deskew_if #(parameter int LANES = 4);
  logic lmfc_edge;
  logic [3:0] release_dly;
  logic [16*LANES-1:0] in_data;
  logic [2*LANES-1:0] in_datak;
  logic [2*LANES-1:0] in_err;
  logic sync_n;
  logic [16*LANES-1:0] out_data;
  logic out_valid;
  logic [LANES-1:0] lane_ok;
  logic deskew_err;
  modport master(output lmfc_edge, release_dly, in_data, in_datak, in_err,
                 input sync_n, out_data, out_valid, lane_ok, deskew_err);
  modport slave(input lmfc_edge, release_dly, in_data, in_datak, in_err,
                output sync_n, out_data, out_valid, lane_ok, deskew_err);
endinterface

// File: rtl/jesd_rx_lane_deskew.sv
// jesd_rx_lane_deskew: JESD204B receive CGS/ILAS sync and multi-lane elastic-buffer deskew
module jesd_rx_lane_deskew #(
  parameter int LANES = 4,
  parameter int DEPTH = 8,
  parameter int CGS_COUNT = 4,
  parameter int ERR_LIMIT = 8
) (
  input logic clk,
  input logic rst,
  jesd_rx_lane_deskew_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CGS_COUNT + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  typedef enum logic [2:0] {CGS, WAIT_LMFC, ILAS_WAIT, RELEASE, DATA} state_t;
  state_t state;
  logic [15:0] mem [LANES][DEPTH];
  logic [AW:0] wp [LANES];
  logic [AW:0] rp;
  logic [CW-1:0] cc [LANES];
  logic [LANES-1:0] started, clean, is_r, wr, full, ok_nx;
  logic [16*LANES-1:0] rd_data;
  logic [3:0] rc;
  logic [EW-1:0] ec, ec_nx;
  logic rd, run, ovf;
  always_comb begin
    run = state inside {ILAS_WAIT, RELEASE, DATA};
    rd = state == DATA || (state == RELEASE && rc == 4'd0);
    ec_nx = (bus.lmfc_edge ? '0 : ec) + EW'(|bus.in_err);
    rd_data = '0;
    clean = '0;
    is_r = '0;
    wr = '0;
    full = '0;
    ok_nx = '0;
    for (int i = 0; i < LANES; i++) begin
      clean[i] = bus.in_datak[2*i+:2] == 2'b11 && bus.in_data[16*i+:16] == 16'hBCBC && bus.in_err[2*i+:2] == 2'b00;
      is_r[i] = bus.in_datak[2*i] && bus.in_data[16*i+:8] == 8'h1C;
      wr[i] = run && (started[i] || is_r[i]);
      full[i] = (wp[i] - rp) == (AW+1)'(DEPTH);
      ok_nx[i] = clean[i] && int'(cc[i]) + 1 >= CGS_COUNT;
      rd_data[16*i+:16] = mem[i][rp[AW-1:0]];
    end
    // a simultaneous lockstep read frees the slot the write needs
    ovf = |(wr & full) && !rd;
  end
  always_ff @(posedge clk)
    for (int i = 0; i < LANES; i++)
      if (wr[i]) mem[i][wp[i][AW-1:0]] <= bus.in_data[16*i+:16];
  always_ff @(posedge clk) begin
    bus.out_valid <= 1'b0;
    bus.out_data <= '0;
    if (rst || ovf || (state == DATA && int'(ec_nx) >= ERR_LIMIT)) begin
      state <= CGS;
      bus.sync_n <= 1'b0;
      bus.lane_ok <= '0;
      bus.deskew_err <= !rst && (bus.deskew_err || ovf);
      started <= '0;
      rp <= '0;
      rc <= '0;
      ec <= '0;
      for (int i = 0; i < LANES; i++) begin
        wp[i] <= '0;
        cc[i] <= '0;
      end
    end else begin
      started <= started | (is_r & {LANES{run}});
      if (rd) rp <= rp + 1'b1;
      for (int i = 0; i < LANES; i++)
        if (wr[i]) wp[i] <= wp[i] + 1'b1;
      case (state)
        CGS: begin
          for (int i = 0; i < LANES; i++)
            cc[i] <= clean[i] ? (int'(cc[i]) >= CGS_COUNT ? cc[i] : cc[i] + 1'b1) : '0;
          bus.lane_ok <= ok_nx;
          if (&ok_nx) state <= WAIT_LMFC;
        end
        WAIT_LMFC: if (bus.lmfc_edge) begin
          state <= ILAS_WAIT;
          bus.sync_n <= 1'b1;
        end
        // started is registered, so an edge on the last lane's start beat is skipped
        ILAS_WAIT: if (&started && bus.lmfc_edge) begin
          state <= RELEASE;
          rc <= bus.release_dly;
        end
        RELEASE: if (rc == 4'd0) begin
          state <= DATA;
          bus.out_valid <= 1'b1;
          bus.out_data <= rd_data;
        end else rc <= rc - 1'b1;
        DATA: begin
          ec <= ec_nx;
          bus.out_valid <= 1'b1;
          bus.out_data <= rd_data;
        end
        default: state <= CGS;
      endcase
    end
  end
endmodule

// File: tb/tb_jesd_rx_lane_deskew.sv
// tb_jesd_rx_lane_deskew: vector table, directed corner sequences and randomized skew runs vs a queue model
module tb_jesd_rx_lane_deskew;
  localparam int L = 4;
  localparam logic [63:0] KBC = {4{16'hBCBC}};
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  jesd_rx_lane_deskew_if #(.LANES(L)) bus();
  jesd_rx_lane_deskew #(.LANES(L), .DEPTH(8), .CGS_COUNT(4), .ERR_LIMIT(8)) dut(.clk(clk), .rst(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  typedef struct packed {
    logic [63:0] d;
    logic [7:0] k;
    logic [7:0] e;
    logic l;
    logic [3:0] ok;
    logic sn;
  } vec_t;
  vec_t v [13];
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [63:0] d, input logic [7:0] k, input logic [7:0] e, input logic l);
    bus.in_data = d;
    bus.in_datak = k;
    bus.in_err = e;
    bus.lmfc_edge = l;
  endtask
  task automatic sync_up(input bit do_rst);
    if (do_rst) begin
      rst = 1'b1;
      drive(64'h0, 8'h0, 8'h0, 1'b0);
      tick;
      rst = 1'b0;
    end
    repeat (4) begin
      drive(KBC, 8'hFF, 8'h0, 1'b0);
      tick;
    end
    chk("sync lane_ok", 64'(bus.lane_ok), 64'hF);
    drive(KBC, 8'hFF, 8'h0, 1'b1);
    tick;
    chk("sync sync_n", 64'(bus.sync_n), 64'h1);
  endtask
  // lane i starts its /R/ at beat skv[4i+:4]; release edge at beat te; model: per-lane queues from /R/ onward
  task automatic run_lanes(input logic [15:0] skv, input int te, input bit coin, input int d, input string tag);
    logic [15:0] q [L][$];
    logic [63:0] dv, exp;
    logic [7:0] kv;
    int smax, rel;
    sync_up(1'b1);
    bus.release_dly = 4'(d);
    smax = 0;
    for (int i = 0; i < L; i++) if (int'(skv[4*i+:4]) > smax) smax = int'(skv[4*i+:4]);
    rel = te + 1 + d;
    for (int b = 0; b <= rel + 12; b++) begin
      for (int i = 0; i < L; i++) begin
        int s = int'(skv[4*i+:4]);
        logic [15:0] w;
        if (b < s) begin
          w = 16'hBCBC;
          kv[2*i+:2] = 2'b11;
        end else begin
          w = (b == s) ? {8'($urandom), 8'h1C} : 16'($urandom);
          kv[2*i+:2] = (b == s) ? 2'b01 : 2'b00;
          q[i].push_back(w);
        end
        dv[16*i+:16] = w;
      end
      drive(dv, kv, 8'h0, b == te || (coin && b == smax));
      tick;
      exp = '0;
      if (b >= rel) for (int i = 0; i < L; i++) exp[16*i+:16] = q[i].pop_front();
      chk({tag, " valid"}, 64'(bus.out_valid), 64'(b >= rel));
      chk({tag, " data"}, bus.out_data, exp);
    end
  endtask
  task automatic to_data;
    sync_up(1'b1);
    bus.release_dly = 4'd0;
    drive({4{16'h001C}}, 8'h55, 8'h0, 1'b0);
    tick;
    drive({4{16'h1234}}, 8'h0, 8'h0, 1'b1);
    tick;
    drive({4{16'h5678}}, 8'h0, 8'h0, 1'b0);
    tick;
    chk("to_data valid", 64'(bus.out_valid), 64'h1);
    chk("to_data first", bus.out_data, {4{16'h001C}});
  endtask
  task automatic err_beat(input int n);
    drive({$urandom, $urandom}, 8'h0, 8'(1 << (n % 8)), 1'b0);
    tick;
  endtask
  initial begin
    rst = 1'b1;
    drive(64'h0, 8'h0, 8'h0, 1'b0);
    bus.release_dly = 4'd0;
    tick;
    chk("rst sync_n", 64'(bus.sync_n), 64'h0);
    chk("rst out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst out_data", bus.out_data, 64'h0);
    chk("rst lane_ok", 64'(bus.lane_ok), 64'h0);
    chk("rst deskew_err", 64'(bus.deskew_err), 64'h0);
    rst = 1'b0;
    v[0] = '{KBC, 8'hFF, 8'h00, 1'b0, 4'h0, 1'b0};
    v[1] = v[0];
    v[2] = v[0];
    v[3] = '{KBC, 8'hF3, 8'h00, 1'b0, 4'hD, 1'b0};
    v[4] = '{{16'hBCBC, 16'hBCBC, 16'hBCBC, 16'hBCBD}, 8'hFF, 8'h08, 1'b0, 4'hC, 1'b0};
    v[5] = '{KBC, 8'hFF, 8'h00, 1'b0, 4'hC, 1'b0};
    v[6] = v[5];
    v[7] = v[5];
    v[8] = '{KBC, 8'hFF, 8'h00, 1'b0, 4'hF, 1'b0};
    v[9] = '{64'h0, 8'h00, 8'h00, 1'b0, 4'hF, 1'b0};
    v[10] = '{KBC, 8'hFF, 8'hFF, 1'b0, 4'hF, 1'b0};
    v[11] = '{KBC, 8'hFF, 8'h00, 1'b1, 4'hF, 1'b1};
    v[12] = '{64'h0, 8'h00, 8'h00, 1'b0, 4'hF, 1'b1};
    for (int n = 0; n < 13; n++) begin
      drive(v[n].d, v[n].k, v[n].e, v[n].l);
      tick;
      chk($sformatf("vec%0d lane_ok", n), 64'(bus.lane_ok), 64'(v[n].ok));
      chk($sformatf("vec%0d sync_n", n), 64'(bus.sync_n), 64'(v[n].sn));
    end
    run_lanes(16'h3210, 4, 1'b0, 0, "skew0123");
    run_lanes(16'h1100, 2, 1'b0, 5, "dly5");
    run_lanes(16'h2031, 4, 1'b1, 2, "coin");
    for (int r = 0; r < 6; r++) begin
      logic [15:0] skv;
      int smx, smn, te, d;
      bit coin;
      smx = 0;
      smn = 15;
      for (int i = 0; i < L; i++) begin
        int s = int'($urandom_range(0, 3));
        skv[4*i+:4] = 4'(s);
        if (s > smx) smx = s;
        if (s < smn) smn = s;
      end
      te = smx + 1 + int'($urandom_range(0, 1));
      d = int'($urandom_range(0, 7 - te + smn));
      coin = 1'($urandom_range(0, 1));
      run_lanes(skv, te, coin, d, "rand");
    end
    sync_up(1'b1);
    for (int b = 0; b <= 8; b++) begin
      drive({16'hBCBC, {3{(b == 0) ? 16'h001C : 16'($urandom)}}}, (b == 0) ? 8'hD5 : 8'hC0, 8'h0, 1'b0);
      tick;
      chk("ovf deskew_err", 64'(bus.deskew_err), 64'(b == 8));
      chk("ovf sync_n", 64'(bus.sync_n), 64'(b < 8));
    end
    chk("ovf lane_ok", 64'(bus.lane_ok), 64'h0);
    sync_up(1'b0);
    chk("ovf sticky", 64'(bus.deskew_err), 64'h1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("ovf rst clears", 64'(bus.deskew_err), 64'h0);
    to_data;
    for (int n = 1; n <= 8; n++) begin
      err_beat(n);
      chk("err8 sync_n", 64'(bus.sync_n), 64'(n < 8));
      chk("err8 valid", 64'(bus.out_valid), 64'(n < 8));
    end
    to_data;
    for (int n = 1; n <= 7; n++) err_beat(n);
    drive(64'h0, 8'h0, 8'h0, 1'b1);
    tick;
    for (int n = 1; n <= 7; n++) err_beat(n);
    chk("err7x2 sync_n", 64'(bus.sync_n), 64'h1);
    chk("err7x2 valid", 64'(bus.out_valid), 64'h1);
    err_beat(0);
    chk("err7x2+1 sync_n", 64'(bus.sync_n), 64'h0);
    to_data;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rstdata sync_n", 64'(bus.sync_n), 64'h0);
    chk("rstdata valid", 64'(bus.out_valid), 64'h0);
    chk("rstdata data", bus.out_data, 64'h0);
    chk("rstdata lane_ok", 64'(bus.lane_ok), 64'h0);
    chk("rstdata deskew_err", 64'(bus.deskew_err), 64'h0);
    drive(KBC, 8'hFF, 8'h0, 1'b1);
    tick;
    chk("rstdata cgs lane_ok", 64'(bus.lane_ok), 64'h0);
    chk("rstdata cgs sync_n", 64'(bus.sync_n), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jesd_rx_lane_deskew.md
JESD_RX_LANE_DESKEW -- requirements
Module: jesd_rx_lane_deskew

Interface
REQ-001 SHALL have parameter LANES, default 4: number of received lanes, each carrying 16 bits/2 octets per clk beat.
REQ-002 SHALL have parameter DEPTH, default 8: per-lane elastic buffer depth in beats (power of 2, 4..32).
REQ-003 SHALL have parameter CGS_COUNT, default 4: consecutive clean /K/ beats required for a lane to be synced.
REQ-004 SHALL have parameter ERR_LIMIT, default 8: errored beats per multiframe that force resync.
REQ-005 clk  in  1  single clock for the whole block; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 lmfc_edge  in  1  one-beat pulse at each local multiframe boundary.
REQ-008 release_dly  in  4  extra beats to wait after release LMFC edge (0..15).
REQ-009 in_data  in  16*LANES  word-aligned lane data, lane i at [16i+15:16i], octet0 in low byte.
REQ-010 in_datak  in  2*LANES  control flag per octet.
REQ-011 in_err  in  2*LANES  per-octet disparity OR not-in-table error.
REQ-012 sync_n  out  1  JESD SYNC~, active low.
REQ-013 out_data  out  16*LANES  deskewed data, same lane packing.
REQ-014 out_valid  out  1  out_data valid.
REQ-015 lane_ok  out  LANES  per-lane CGS achieved.
REQ-016 deskew_err  out  1  sticky overflow/misalign flag, cleared only by rst.

Function
REQ-017 SHALL implement FSM states CGS, WAIT_LMFC, ILAS_WAIT, RELEASE, DATA.
REQ-018 Clean /K/ beat: both octets K with value 0xBC and no in_err; lane_ok[i] sets after CGS_COUNT consecutive clean beats, and clears on any non-/K/ or errored beat while in CGS.
REQ-019 CGS: sync_n=0; all lane_ok=1 -> WAIT_LMFC.
REQ-020 WAIT_LMFC: sync_n=0; on lmfc_edge, sync_n=1 from the next beat and -> ILAS_WAIT.
REQ-021 ILAS_WAIT: lane i starts when octet0 is K 0x1C (/R/); that beat is the first written to lane i's buffer, and every later beat is written each cycle.
REQ-022 All lanes started -> next lmfc_edge starts a release_dly down-counter -> RELEASE; release_dly=0 releases on the beat after that edge.
REQ-023 Release: all buffers read in lockstep each beat from then on; out_data registered, 1 beat after read; out_valid=1 from the first released /R/ beat onward; FSM -> DATA.
REQ-024 Buffer overflow (any lane holding DEPTH unread beats, write attempted) SHALL set deskew_err and -> CGS with all buffers flushed.
REQ-025 Skew between first and last started lane of >= DEPTH beats is the overflow case of REQ-024.
REQ-026 DATA: per-multiframe error counter (beats with any in_err bit) clears on lmfc_edge; reaching ERR_LIMIT -> CGS, deskew_err unaffected.
REQ-027 Errors and /K/ 0xBC outside CGS do not alter lane_ok.
REQ-028 In any state other than DATA, out_valid=0 and out_data=0.
REQ-029 Entry to CGS from any state: sync_n=0 on the next beat, buffers flushed, lane_ok cleared.
REQ-030 lmfc_edge coincident with the last lane start: edge not used; release waits for the following edge.

Reset
REQ-031 On rst: state CGS, sync_n=0, out_data=0, out_valid=0, lane_ok=0, deskew_err=0, buffers empty, counters 0; rst mid-DATA takes effect the following beat.

Verification
REQ-032 4 lanes, 4 beats of 0xBCBC K=11 each -> lane_ok=4'hF on 4th beat+1, sync_n=1 beat after next lmfc_edge.
REQ-033 Lane skews 0,1,2,3 beats of /R/ start, release_dly=0 -> out_valid rises same beat for all lanes; first out_data word every lane = 0x??1C octet0.
REQ-034 Lane 3 delayed 9 beats, DEPTH=8 -> deskew_err=1, sync_n=0 next beat, state CGS.
REQ-035 DATA, 8 errored beats within one multiframe -> sync_n=0; 7 errors then lmfc_edge then 7 -> stays DATA.
REQ-036 release_dly=5 -> out_valid rises 1+5+1 beats after release lmfc_edge.
REQ-037 rst asserted one beat during DATA -> all outputs 0 next beat, CGS re-entered, lane_ok=0.
